// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/commit controller driving an external 8-bit ALU.
// Ports:
//   CLK, RESET_N            clock and asynchronous active-low reset
//   INSTR, INSTR_VALID      instruction word and its valid flag
//   INSTR_READY             high in IDLE, when an instruction can be accepted
//   PC                      address of the next instruction to fetch
//   DATA1, DATA2, SELECT    ALU operands and operation select
//   RESULT, ZERO            ALU result and zero flag, sampled only in COMMIT
//   ILLEGAL                 one-cycle pulse in COMMIT for an unknown opcode
//   DBG_ADDR, DBG_DATA      combinational register file read port
module alu_issue_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int PC_W        = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [31:0]     INSTR,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    output logic [PC_W-1:0] PC,
    output logic [7:0]      DATA1,
    output logic [7:0]      DATA2,
    output logic [2:0]      SELECT,
    input  logic [7:0]      RESULT,
    input  logic            ZERO,
    output logic            ILLEGAL,
    input  logic [2:0]      DBG_ADDR,
    output logic [7:0]      DBG_DATA
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_op;
    logic [7:0]        r_dest;
    logic [3:0]        r_cnt;
    logic [7:0]        r_regs [8];
    logic [7:0]        r_data1, r_data2;
    logic [2:0]        r_select;
    logic [PC_W-1:0]   r_pc;

    logic              w_accept;
    logic [7:0]        w_op, w_src1, w_src2, w_data2;
    logic [2:0]        w_select;
    logic              w_write, w_illegal, w_take;
    logic [PC_W-1:0]   w_off;
    logic              w_unused;

    assign w_unused = ^INSTR[15:11];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        INSTR_READY = 1'b0;
        case (r_state)
            S_IDLE: begin
                INSTR_READY = 1'b1;
                if (INSTR_VALID) w_next = S_ISSUE;
            end
            S_ISSUE:  w_next = S_WAIT;
            // <= rather than == so a zero count can never stall the FSM
            S_WAIT:   if (r_cnt <= 4'd1) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_accept = INSTR_READY && INSTR_VALID;

    // Operands are decoded from the incoming word so they are already on the ALU during ISSUE
    assign w_op     = INSTR[31:24];
    assign w_src1   = r_regs[INSTR[10:8]];
    assign w_src2   = r_regs[INSTR[2:0]];
    assign w_data2  = (w_op == 8'h00) ? INSTR[7:0] :
                      (w_op == 8'h03 || w_op == 8'h07) ? (~w_src2 + 8'd1) : w_src2;
    assign w_select = (w_op == 8'h02 || w_op == 8'h03 || w_op == 8'h07) ? 3'b001 :
                      (w_op == 8'h04) ? 3'b010 :
                      (w_op == 8'h05) ? 3'b011 : 3'b000;

    assign w_write   = r_op <= 8'h05;
    assign w_illegal = r_op > 8'h07;
    assign w_take    = (r_op == 8'h06) || (r_op == 8'h07 && ZERO);
    assign w_off     = {{(PC_W-10){r_dest[7]}}, r_dest, 2'b00};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_op     <= '0;
            r_dest   <= '0;
            r_cnt    <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            r_select <= '0;
            r_pc     <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= w_op;
                r_dest   <= INSTR[23:16];
                r_data1  <= w_src1;
                r_data2  <= w_data2;
                r_select <= w_select;
            end
            if (r_state == S_ISSUE) r_cnt <= 4'(WAIT_CYCLES);
            if (r_state == S_WAIT)  r_cnt <= r_cnt - 4'd1;
            if (r_state == S_COMMIT) begin
                if (w_write) r_regs[r_dest[2:0]] <= RESULT;
                r_pc <= r_pc + PC_W'(4) + (w_take ? w_off : '0);
            end
        end
    end

    assign PC       = r_pc;
    assign DATA1    = r_data1;
    assign DATA2    = r_data2;
    assign SELECT   = r_select;
    assign ILLEGAL  = (r_state == S_COMMIT) && w_illegal;
    assign DBG_DATA = r_regs[DBG_ADDR];
endmodule
